// File: rtl/gap_junction_stream_gen.sv
// gap_junction_stream_gen: AXI-Stream traffic source for the gap-junction
// core input_r stream. Emits NUM_FRAMES frames of FRAME_LEN words.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   start             one-cycle pulse, begins a run from IDLE or DONE
//   mode              0 counter, 1 LFSR, 2 frame/word index, 3 counter
//   input_r_*_0       AXIS master (TVALID, TLAST, TDATA, TREADY in)
//   busy, done        run status (SEND/GAP, DONE)
//   frames_sent       frames whose TLAST beat was accepted (saturating)
//   stall_cycles      cycles with TVALID=1 and TREADY=0 (saturating)

module gap_junction_stream_gen #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned FRAME_LEN   = 16,
    parameter int unsigned NUM_FRAMES  = 4,
    parameter int unsigned GAP_CYCLES  = 0,
    parameter int unsigned STOP_CYCLES = 20000,
    parameter logic [31:0] SEED        = 32'h1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic              input_r_TVALID_0,
    output logic              input_r_TLAST_0,
    output logic [DATA_W-1:0] input_r_TDATA_0,
    input  logic              input_r_TREADY_0,
    output logic              busy,
    output logic              done,
    output logic [31:0]       frames_sent,
    output logic [31:0]       stall_cycles
);

    localparam int unsigned H  = DATA_W / 2;
    localparam int unsigned IW = (H > 32) ? H : 32;

    localparam logic [DATA_W-1:0] SEED_T    = DATA_W'(SEED);
    localparam logic [IW-1:0]     LAST_WORD = IW'(FRAME_LEN - 1);
    localparam logic [IW-1:0]     FRAMES    = IW'(NUM_FRAMES);
    localparam logic [IW-1:0]     GAP_END   = IW'(GAP_CYCLES - 1);
    localparam logic [31:0]       STOP_LIM  = 32'(STOP_CYCLES);

    // Galois taps; non-32-bit widths fall back to x^W + x^1 + 1 style taps
    localparam logic [DATA_W-1:0] TAPS = (DATA_W == 32) ?
        DATA_W'(32'h8020_0003) :
        ({1'b1, {(DATA_W-1){1'b0}}} | DATA_W'(3));

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        DONE
    } state_t;

    state_t            state;
    logic [1:0]        mode_q;
    logic [IW-1:0]     word_idx;
    logic [IW-1:0]     frame_idx;
    logic [IW-1:0]     gap_cnt;
    logic [31:0]       cycle_cnt;
    logic              stop_req;
    logic [DATA_W-1:0] pat;

    logic              accept;
    logic              at_last;
    logic [IW-1:0]     word_nx;
    logic [IW-1:0]     frame_nx;
    logic              last_nx;
    logic              more;
    logic [DATA_W-1:0] pat_nx;
    logic [DATA_W-1:0] data_nx;
    logic [DATA_W-1:0] start_pat;
    logic [DATA_W-1:0] start_data;

    function automatic logic [DATA_W-1:0] lfsr_step(
        input logic [DATA_W-1:0] x
    );
        lfsr_step = x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
    endfunction

    assign accept   = input_r_TVALID_0 & input_r_TREADY_0;
    assign at_last  = (word_idx == LAST_WORD);
    assign word_nx  = at_last ? '0 : word_idx + IW'(1);
    assign frame_nx = at_last ? frame_idx + IW'(1) : frame_idx;
    assign last_nx  = (word_nx == LAST_WORD);
    assign more     = (NUM_FRAMES == 0) || (frame_nx < FRAMES);

    // Pattern state advances on every accepted beat; index mode is
    // derived from the next word/frame position instead.
    assign pat_nx  = (mode_q == 2'd1) ? lfsr_step(pat) : pat + DATA_W'(1);
    assign data_nx = (mode_q == 2'd2) ?
                     {frame_nx[H-1:0], word_nx[H-1:0]} : pat_nx;

    // An all-zero LFSR would lock up, so a zero seed becomes 1
    assign start_pat  = (mode == 2'd1 && SEED_T == '0) ?
                        DATA_W'(1) : SEED_T;
    assign start_data = (mode == 2'd2) ? '0 : start_pat;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            input_r_TVALID_0 <= 1'b0;
            input_r_TLAST_0  <= 1'b0;
            input_r_TDATA_0  <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            frames_sent      <= '0;
            stall_cycles     <= '0;
            mode_q           <= '0;
            word_idx         <= '0;
            frame_idx        <= '0;
            gap_cnt          <= '0;
            cycle_cnt        <= '0;
            stop_req         <= 1'b0;
            pat              <= SEED_T;
        end else begin
            if (state == SEND || state == GAP) begin
                if (cycle_cnt != '1) begin
                    cycle_cnt <= cycle_cnt + 32'd1;
                end
                if (STOP_CYCLES != 0 && cycle_cnt >= STOP_LIM - 32'd1) begin
                    stop_req <= 1'b1;
                end
            end

            if (input_r_TVALID_0 && !input_r_TREADY_0 &&
                stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 32'd1;
            end

            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state            <= SEND;
                        mode_q           <= mode;
                        pat              <= start_pat;
                        input_r_TDATA_0  <= start_data;
                        input_r_TVALID_0 <= 1'b1;
                        input_r_TLAST_0  <= (FRAME_LEN == 1);
                        word_idx         <= '0;
                        frame_idx        <= '0;
                        gap_cnt          <= '0;
                        cycle_cnt        <= '0;
                        stop_req         <= 1'b0;
                        frames_sent      <= '0;
                        stall_cycles     <= '0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                    end
                end
                SEND: begin
                    if (accept) begin
                        pat             <= pat_nx;
                        input_r_TDATA_0 <= data_nx;
                        input_r_TLAST_0 <= last_nx;
                        word_idx        <= word_nx;
                        frame_idx       <= frame_nx;
                        if (at_last) begin
                            if (frames_sent != '1) begin
                                frames_sent <= frames_sent + 32'd1;
                            end
                            // A budget stop is honoured only at frame end
                            if (stop_req || !more) begin
                                state            <= DONE;
                                input_r_TVALID_0 <= 1'b0;
                                input_r_TLAST_0  <= 1'b0;
                                busy             <= 1'b0;
                                done             <= 1'b1;
                            end else if (GAP_CYCLES != 0) begin
                                state            <= GAP;
                                input_r_TVALID_0 <= 1'b0;
                                gap_cnt          <= '0;
                            end
                        end
                    end
                end
                GAP: begin
                    if (stop_req) begin
                        state           <= DONE;
                        input_r_TLAST_0 <= 1'b0;
                        busy            <= 1'b0;
                        done            <= 1'b1;
                    end else if (gap_cnt == GAP_END) begin
                        state            <= SEND;
                        input_r_TVALID_0 <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + IW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gap_junction_stream_gen.sv
// tb_gap_junction_stream_gen: directed bench for gap_junction_stream_gen
// with default, inter-frame-gap and stop-budget configurations.

module tb_gap_junction_stream_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start_a = 1'b0;
    logic [1:0]  mode_a = 2'd0;
    logic        ready_a = 1'b0;
    logic        valid_a, last_a, busy_a, done_a;
    logic [31:0] data_a, fs_a, st_a;

    logic        start_b = 1'b0;
    logic [1:0]  mode_b = 2'd0;
    logic        ready_b = 1'b0;
    logic        valid_b, last_b, busy_b, done_b;
    logic [31:0] data_b, fs_b, st_b;

    logic        start_c = 1'b0;
    logic [1:0]  mode_c = 2'd0;
    logic        ready_c = 1'b0;
    logic        valid_c, last_c, busy_c, done_c;
    logic [31:0] data_c, fs_c, st_c;

    int checks = 0;
    int errors = 0;

    logic [31:0] bdata [0:127];
    logic        blast [0:127];
    int          nbeats;
    int          nstalls;

    always #5 clk = ~clk;

    gap_junction_stream_gen dut_a (
        .clk(clk), .reset(reset), .start(start_a), .mode(mode_a),
        .input_r_TVALID_0(valid_a), .input_r_TLAST_0(last_a),
        .input_r_TDATA_0(data_a), .input_r_TREADY_0(ready_a),
        .busy(busy_a), .done(done_a),
        .frames_sent(fs_a), .stall_cycles(st_a)
    );

    gap_junction_stream_gen #(
        .FRAME_LEN(4), .NUM_FRAMES(3), .GAP_CYCLES(3)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .mode(mode_b),
        .input_r_TVALID_0(valid_b), .input_r_TLAST_0(last_b),
        .input_r_TDATA_0(data_b), .input_r_TREADY_0(ready_b),
        .busy(busy_b), .done(done_b),
        .frames_sent(fs_b), .stall_cycles(st_b)
    );

    gap_junction_stream_gen #(
        .NUM_FRAMES(0), .STOP_CYCLES(40)
    ) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .mode(mode_c),
        .input_r_TVALID_0(valid_c), .input_r_TLAST_0(last_c),
        .input_r_TDATA_0(data_c), .input_r_TREADY_0(ready_c),
        .busy(busy_c), .done(done_c),
        .frames_sent(fs_c), .stall_cycles(st_c)
    );

    task automatic check_w(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs,
                           input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    // Runs dut_a once; TREADY high on every rdiv-th cycle
    task automatic run_a(input logic [1:0] m, input int rdiv);
        int          cyc;
        logic        hold;
        logic [31:0] pd;
        logic        pl;
        nbeats  = 0;
        nstalls = 0;
        hold    = 1'b0;
        pd      = '0;
        pl      = 1'b0;
        @(negedge clk);
        mode_a  = m;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check_b("start_latency", valid_a, 1'b1);
        cyc = 0;
        while (!done_a && cyc < 2000) begin
            if (hold) begin
                check_b("hold_valid", valid_a, 1'b1);
                check_w("hold_data", data_a, pd);
                check_b("hold_last", last_a, pl);
            end
            ready_a = (rdiv <= 1) || (cyc % rdiv == 0);
            if (valid_a && ready_a) begin
                if (nbeats < 128) begin
                    bdata[nbeats] = data_a;
                    blast[nbeats] = last_a;
                end
                nbeats++;
                hold = 1'b0;
            end else if (valid_a) begin
                nstalls++;
                hold = 1'b1;
                pd   = data_a;
                pl   = last_a;
            end else begin
                hold = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        check_b("run_a_done", done_a, 1'b1);
        ready_a = 1'b0;
    endtask

    initial begin
        int   k;
        int   lastpos;
        int   done_cyc;
        int   late_valid;
        logic ev;

        repeat (3) @(negedge clk);
        check_b("rst_valid", valid_a, 1'b0);
        check_b("rst_last", last_a, 1'b0);
        check_w("rst_data", data_a, 32'h0);
        check_b("rst_busy", busy_a, 1'b0);
        check_b("rst_done", done_a, 1'b0);
        check_w("rst_frames", fs_a, 32'd0);
        check_w("rst_stalls", st_a, 32'd0);
        check_b("rst_valid_b", valid_b, 1'b0);
        check_b("rst_valid_c", valid_c, 1'b0);
        reset = 1'b0;

        // Counter mode, always ready
        run_a(2'd0, 1);
        check_w("t1_beats", nbeats, 32'd64);
        for (int i = 0; i < 64; i++) begin
            check_w("t1_data", bdata[i], i + 1);
            check_b("t1_last", blast[i], (i % 16) == 15);
        end
        check_w("t1_frames", fs_a, 32'd4);
        check_w("t1_stalls", st_a, 32'd0);
        check_b("t1_done", done_a, 1'b1);
        check_b("t1_busy", busy_a, 1'b0);
        check_b("t1_valid_off", valid_a, 1'b0);

        // Ready one cycle in three
        run_a(2'd0, 3);
        check_w("t2_beats", nbeats, 32'd64);
        for (int i = 0; i < 64; i++) begin
            check_w("t2_data", bdata[i], i + 1);
            check_b("t2_last", blast[i], (i % 16) == 15);
        end
        check_w("t2_stalls_hand", st_a, 32'd126);
        check_w("t2_stalls_seen", st_a, nstalls);
        check_w("t2_frames", fs_a, 32'd4);

        // LFSR mode
        run_a(2'd1, 1);
        check_w("t3_lfsr_beats", nbeats, 32'd64);
        check_w("t3_lfsr0", bdata[0], 32'h0000_0001);
        check_w("t3_lfsr1", bdata[1], 32'h8020_0003);
        check_w("t3_lfsr2", bdata[2], 32'hC030_0002);
        check_b("t3_lfsr_last", blast[15], 1'b1);

        // Index mode
        run_a(2'd2, 1);
        check_w("t3_idx_beats", nbeats, 32'd64);
        check_w("t3_idx_first", bdata[0], 32'h0000_0000);
        check_w("t3_idx_f1w1", bdata[17], 32'h0001_0001);
        check_w("t3_idx_f2w5", bdata[37], 32'h0002_0005);
        check_w("t3_idx_f3w15", bdata[63], 32'h0003_000F);

        // Inter-frame gap of 3 cycles, 3 frames of 4 words
        @(negedge clk);
        ready_b = 1'b1;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        k = 0;
        for (int c = 0; c < 30; c++) begin
            ev = (c < 4) || (c >= 7 && c < 11) || (c >= 14 && c < 18);
            check_b("t4_valid", valid_b, ev);
            if (valid_b) begin
                check_w("t4_data", data_b, k + 1);
                check_b("t4_last", last_b, (k % 4) == 3);
                k++;
            end
            @(negedge clk);
        end
        check_w("t4_beats", k, 32'd12);
        check_b("t4_done", done_b, 1'b1);
        check_w("t4_frames", fs_b, 32'd3);

        // Unlimited frames, 40-cycle budget, ready from cycle 30
        @(negedge clk);
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        k        = 0;
        lastpos  = -1;
        done_cyc = -1;
        for (int c = 0; c < 200; c++) begin
            if (done_c) begin
                done_cyc = c;
                break;
            end
            ready_c = (c >= 30);
            if (valid_c && ready_c) begin
                check_w("t5_data", data_c, k + 1);
                if (last_c) lastpos = k;
                k++;
            end
            @(negedge clk);
        end
        check_w("t5_done_cyc", done_cyc, 32'd46);
        check_w("t5_beats", k, 32'd16);
        check_w("t5_lastpos", lastpos, 32'd15);
        check_w("t5_frames", fs_c, 32'd1);
        check_w("t5_stalls", st_c, 32'd30);
        late_valid = 0;
        repeat (20) begin
            if (valid_c) late_valid++;
            @(negedge clk);
        end
        check_w("t5_no_valid", late_valid, 32'd0);
        check_b("t5_done_hold", done_c, 1'b1);
        ready_c = 1'b0;

        // Reset mid-frame, then restart
        @(negedge clk);
        mode_a  = 2'd0;
        ready_a = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (23) @(negedge clk);
        check_b("t6_pre_valid", valid_a, 1'b1);
        check_w("t6_pre_data", data_a, 32'd24);
        check_w("t6_pre_frames", fs_a, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_b("t6_rst_valid", valid_a, 1'b0);
        check_b("t6_rst_last", last_a, 1'b0);
        check_w("t6_rst_frames", fs_a, 32'd0);
        check_w("t6_rst_stalls", st_a, 32'd0);
        check_b("t6_rst_busy", busy_a, 1'b0);
        check_b("t6_rst_done", done_a, 1'b0);
        reset   = 1'b0;
        ready_a = 1'b0;
        run_a(2'd0, 1);
        check_w("t6_restart_first", bdata[0], 32'd1);
        check_w("t6_restart_beats", nbeats, 32'd64);
        check_w("t6_restart_frames", fs_a, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
